// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter controller.
//   pc_state_t  : FSM state encoding (run / single-step / halted)
//   INSTR_BYTES : instruction size in bytes, used for the PC+4 / PC+8 adders
//   ALIGN_MASK  : low PC bits that must be zero for a word-aligned target
//   ctx_width() : index width for a given context count (never below 1)
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_t;

    localparam int         INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    function automatic int ctx_width(input int n_ctx);
        return (n_ctx > 1) ? $clog2(n_ctx) : 1;
    endfunction

endpackage

// File: rtl/pc_if.sv
// pc_if: signal bundle between the next-PC / debug side (master) and the
// PC controller (slave).
//   master drives : i_mode, i_step, i_pc_write, i_NPC, i_halt, i_resume
//   slave drives  : o_pc, o_pc_4, o_pc_8, o_ctx, o_halted, o_misaligned,
//                   o_committed
interface pc_if #(
    parameter int NBITS = 32,
    parameter int N_CTX = 1
);
    import pc_pkg::*;

    localparam int CTXW = ctx_width(N_CTX);

    logic             i_mode;
    logic             i_step;
    logic             i_pc_write;
    logic [NBITS-1:0] i_NPC;
    logic             i_halt;
    logic             i_resume;
    logic [NBITS-1:0] o_pc;
    logic [NBITS-1:0] o_pc_4;
    logic [NBITS-1:0] o_pc_8;
    logic [CTXW-1:0]  o_ctx;
    logic             o_halted;
    logic             o_misaligned;
    logic             o_committed;

    modport master (
        output i_mode, i_step, i_pc_write, i_NPC, i_halt, i_resume,
        input  o_pc, o_pc_4, o_pc_8, o_ctx, o_halted, o_misaligned, o_committed
    );

    modport slave (
        input  i_mode, i_step, i_pc_write, i_NPC, i_halt, i_resume,
        output o_pc, o_pc_4, o_pc_8, o_ctx, o_halted, o_misaligned, o_committed
    );

endinterface

// File: rtl/pc_ctx_bank.sv
// pc_ctx_bank: one PC register per hardware context.
//   clk, rst_n        : clock, async active-low reset (all entries -> RESET_VECTOR)
//   wr_en/idx/data    : single write port
//   rd_idx / rd_data  : single combinational read port
module pc_ctx_bank #(
    parameter int               NBITS        = 32,
    parameter int               N_CTX        = 1,
    parameter int               CTXW         = 1,
    parameter logic [NBITS-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CTXW-1:0]  wr_idx,
    input  logic [NBITS-1:0] wr_data,
    input  logic [CTXW-1:0]  rd_idx,
    output logic [NBITS-1:0] rd_data
);

    logic [NBITS-1:0] regs [N_CTX];

    // Index compare loops keep a single-entry bank free of a zero-width index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CTX; i++) regs[i] <= RESET_VECTOR;
        end else if (wr_en) begin
            for (int i = 0; i < N_CTX; i++) begin
                if (wr_idx == CTXW'(i)) regs[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = regs[0];
        for (int i = 1; i < N_CTX; i++) begin
            if (rd_idx == CTXW'(i)) rd_data = regs[i];
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: multi-context program-counter controller with run/step/halt FSM.
//   i_clk, i_reset : clock, async active-low reset
//   bus (slave)    : next-PC, stall, step/halt/resume controls in; active PC,
//                    PC+4, PC+8, context index and status flags out
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_RUN    | advance whenever i_pc_write=1
//   ST_STEP   | advance once per i_step rising edge (one edge may be pending)
//   ST_HALTED | frozen until i_resume; entered on i_halt or misaligned target
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int               NBITS        = 32,
    parameter logic [NBITS-1:0] RESET_VECTOR = '0,
    parameter int               N_CTX        = 1
) (
    input logic  i_clk,
    input logic  i_reset,
    pc_if.slave  bus
);

    localparam int CTXW = ctx_width(N_CTX);

    pc_state_t        state, state_nxt;
    logic             step_q;
    logic             pending_q, pending_nxt;
    logic [CTXW-1:0]  ctx_q, ctx_nxt;
    logic             mis_q, mis_nxt;
    logic             comm_q, comm_nxt;
    logic             wr_en;
    logic             advance;
    logic             step_edge;
    logic [NBITS-1:0] pc_cur;

    assign step_edge = bus.i_step & ~step_q;

    pc_ctx_bank #(
        .NBITS        (NBITS),
        .N_CTX        (N_CTX),
        .CTXW         (CTXW),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_bank (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .wr_en   (wr_en),
        .wr_idx  (ctx_q),
        .wr_data (bus.i_NPC),
        .rd_idx  (ctx_q),
        .rd_data (pc_cur)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_RUN;
            step_q    <= 1'b0;
            pending_q <= 1'b0;
            ctx_q     <= '0;
            mis_q     <= 1'b0;
            comm_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_q    <= bus.i_step;
            pending_q <= pending_nxt;
            ctx_q     <= ctx_nxt;
            mis_q     <= mis_nxt;
            comm_q    <= comm_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending_q;
        ctx_nxt     = ctx_q;
        mis_nxt     = mis_q;
        comm_nxt    = 1'b0;
        wr_en       = 1'b0;
        advance     = 1'b0;

        case (state)
            ST_RUN: begin
                advance     = bus.i_pc_write;
                pending_nxt = 1'b0;
                state_nxt   = bus.i_mode ? ST_STEP : ST_RUN;
            end
            ST_STEP: begin
                // A stalled edge is remembered; extra edges while one is
                // already waiting collapse into it.
                advance = bus.i_pc_write & (step_edge | pending_q);
                if (advance)        pending_nxt = 1'b0;
                else if (step_edge) pending_nxt = 1'b1;
                state_nxt = bus.i_mode ? ST_STEP : ST_RUN;
            end
            ST_HALTED: begin
                pending_nxt = 1'b0;
                if (bus.i_resume) begin
                    mis_nxt   = 1'b0;
                    state_nxt = bus.i_mode ? ST_STEP : ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (advance) begin
            if (bus.i_halt) begin
                state_nxt   = ST_HALTED;
                pending_nxt = 1'b0;
            end else if ((bus.i_NPC[1:0] & ALIGN_MASK) != 2'b00) begin
                mis_nxt     = 1'b1;
                state_nxt   = ST_HALTED;
                pending_nxt = 1'b0;
            end else begin
                wr_en    = 1'b1;
                comm_nxt = 1'b1;
                ctx_nxt  = (ctx_q == CTXW'(N_CTX - 1)) ? '0 : ctx_q + 1'b1;
            end
        end
    end

    assign bus.o_pc         = pc_cur;
    assign bus.o_pc_4       = pc_cur + NBITS'(INSTR_BYTES);
    assign bus.o_pc_8       = pc_cur + NBITS'(2 * INSTR_BYTES);
    assign bus.o_ctx        = ctx_q;
    assign bus.o_halted     = (state == ST_HALTED);
    assign bus.o_misaligned = mis_q;
    assign bus.o_committed  = comm_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    localparam logic [31:0] RV1 = 32'h0000_0000;
    localparam logic [31:0] RV4 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode, step, pc_write, halt, resume;
    logic [31:0] npc;

    always #5 clk = ~clk;

    pc_if #(.NBITS(32), .N_CTX(1)) bus1 ();
    pc_if #(.NBITS(32), .N_CTX(4)) bus4 ();

    assign bus1.i_mode = mode;      assign bus4.i_mode = mode;
    assign bus1.i_step = step;      assign bus4.i_step = step;
    assign bus1.i_pc_write = pc_write; assign bus4.i_pc_write = pc_write;
    assign bus1.i_NPC = npc;        assign bus4.i_NPC = npc;
    assign bus1.i_halt = halt;      assign bus4.i_halt = halt;
    assign bus1.i_resume = resume;  assign bus4.i_resume = resume;

    pc_ctrl #(.NBITS(32), .RESET_VECTOR(RV1), .N_CTX(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .bus(bus1.slave));
    pc_ctrl #(.NBITS(32), .RESET_VECTOR(RV4), .N_CTX(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst_n), .bus(bus4.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int unsigned m_nctx [2] = '{1, 4};
    logic [31:0] m_pc [2][8];
    int          m_ctx [2];
    bit          m_halted [2], m_mis [2], m_comm [2], m_stepmode [2], m_pend [2];
    bit          m_prev;
    bit          chk_en = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_pc[k][i] = (k == 0) ? RV1 : RV4;
            m_ctx[k] = 0; m_halted[k] = 0; m_mis[k] = 0;
            m_comm[k] = 0; m_stepmode[k] = 0; m_pend[k] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_clock(input bit md, input bit st, input bit pw,
                               input bit hl, input bit rs, input logic [31:0] np);
        bit e_s, go;
        e_s = st && !m_prev;
        for (int k = 0; k < 2; k++) begin
            m_comm[k] = 0;
            if (m_halted[k]) begin
                m_pend[k] = 0;
                if (rs) begin
                    m_halted[k] = 0; m_mis[k] = 0; m_stepmode[k] = md;
                end
            end else begin
                if (!m_stepmode[k]) begin
                    go = pw; m_pend[k] = 0;
                end else begin
                    go = pw && (e_s || m_pend[k]);
                    if (go) m_pend[k] = 0;
                    else if (e_s) m_pend[k] = 1;
                end
                if (go) begin
                    if (hl) begin
                        m_halted[k] = 1; m_pend[k] = 0;
                    end else if (np % 4 != 0) begin
                        m_mis[k] = 1; m_halted[k] = 1; m_pend[k] = 0;
                    end else begin
                        m_pc[k][m_ctx[k]] = np;
                        m_ctx[k] = (m_ctx[k] + 1) % m_nctx[k];
                        m_comm[k] = 1;
                    end
                end
                if (!m_halted[k]) m_stepmode[k] = md;
            end
        end
        m_prev = st;
    endtask

    task automatic model_compare();
        logic [31:0] p0, p1;
        p0 = m_pc[0][m_ctx[0]];
        p1 = m_pc[1][m_ctx[1]];
        check("m1_pc",   bus1.o_pc, p0);
        check("m1_pc4",  bus1.o_pc_4, p0 + 32'd4);
        check("m1_pc8",  bus1.o_pc_8, p0 + 32'd8);
        check("m1_ctx",  32'(bus1.o_ctx), 32'(m_ctx[0]));
        check("m1_halt", 32'(bus1.o_halted), 32'(m_halted[0]));
        check("m1_mis",  32'(bus1.o_misaligned), 32'(m_mis[0]));
        check("m1_comm", 32'(bus1.o_committed), 32'(m_comm[0]));
        check("m4_pc",   bus4.o_pc, p1);
        check("m4_pc4",  bus4.o_pc_4, p1 + 32'd4);
        check("m4_pc8",  bus4.o_pc_8, p1 + 32'd8);
        check("m4_ctx",  32'(bus4.o_ctx), 32'(m_ctx[1]));
        check("m4_halt", 32'(bus4.o_halted), 32'(m_halted[1]));
        check("m4_mis",  32'(bus4.o_misaligned), 32'(m_mis[1]));
        check("m4_comm", 32'(bus4.o_committed), 32'(m_comm[1]));
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_clock(mode, step, pc_write, halt, resume, npc);
        #1;
        if (chk_en) model_compare();
    end

    // ---------------- directed table (single-context DUT) ----------------
    typedef struct {
        bit          md, st, pw;
        logic [31:0] np;
        bit          hl, rs;
        logic [31:0] pc;
        bit          halted, mis, comm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit md, input bit st, input bit pw, input logic [31:0] np,
                       input bit hl, input bit rs, input logic [31:0] pc,
                       input bit h, input bit m, input bit c);
        vec_t v;
        v.md = md; v.st = st; v.pw = pw; v.np = np; v.hl = hl; v.rs = rs;
        v.pc = pc; v.halted = h; v.mis = m; v.comm = c;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit md, input bit st, input bit pw, input logic [31:0] np,
                         input bit hl, input bit rs);
        @(negedge clk);
        mode = md; step = st; pc_write = pw; npc = np; halt = hl; resume = rs;
    endtask

    initial begin
        // md st pw npc            hl rs  pc             h m c
        add(0, 0, 1, 32'h4,        0, 0,  32'h4,         0, 0, 1);
        add(0, 0, 1, 32'h8,        0, 0,  32'h8,         0, 0, 1);
        add(0, 0, 1, 32'hC,        0, 0,  32'hC,         0, 0, 1);
        add(0, 0, 0, 32'h40,       0, 0,  32'hC,         0, 0, 0);
        add(0, 0, 0, 32'h40,       0, 0,  32'hC,         0, 0, 0);
        add(0, 0, 1, 32'h40,       0, 0,  32'h40,        0, 0, 1);
        add(1, 0, 1, 32'h10,       0, 0,  32'h10,        0, 0, 1); // still RUN this edge
        add(1, 1, 1, 32'h14,       0, 0,  32'h14,        0, 0, 1); // step edge
        add(1, 1, 1, 32'h18,       0, 0,  32'h14,        0, 0, 0); // held: no more
        add(1, 1, 1, 32'h18,       0, 0,  32'h14,        0, 0, 0);
        add(1, 1, 1, 32'h18,       0, 0,  32'h14,        0, 0, 0);
        add(1, 0, 1, 32'h18,       0, 0,  32'h14,        0, 0, 0);
        add(1, 1, 0, 32'h18,       0, 0,  32'h14,        0, 0, 0); // edge latched
        add(1, 0, 0, 32'h18,       0, 0,  32'h14,        0, 0, 0);
        add(1, 1, 0, 32'h18,       0, 0,  32'h14,        0, 0, 0); // dropped
        add(1, 1, 1, 32'h18,       0, 0,  32'h18,        0, 0, 1); // pending fires
        add(1, 0, 1, 32'h1C,       0, 0,  32'h18,        0, 0, 0); // only one
        add(0, 0, 1, 32'h22,       0, 0,  32'h18,        0, 0, 0); // still STEP
        add(0, 0, 1, 32'h22,       0, 0,  32'h18,        1, 1, 0); // misaligned
        add(0, 0, 1, 32'h24,       1, 0,  32'h18,        1, 1, 0);
        add(0, 0, 1, 32'h24,       0, 1,  32'h18,        0, 0, 0); // resume
        add(0, 0, 1, 32'h24,       0, 0,  32'h24,        0, 0, 1);
        add(0, 0, 1, 32'h28,       1, 0,  32'h24,        1, 0, 0); // halt
        add(0, 0, 1, 32'h28,       1, 1,  32'h24,        0, 0, 0); // resume wins
        add(0, 0, 1, 32'h28,       1, 1,  32'h24,        1, 0, 0); // halt wins
        add(0, 0, 1, 32'h28,       0, 1,  32'h24,        0, 0, 0);
        add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 1);
        add(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 0, 0, 1);

        mode = 0; step = 0; pc_write = 1; npc = 32'h4; halt = 0; resume = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc",    bus1.o_pc, 32'h0);
        check("rst_pc4",   bus1.o_pc_4, 32'h4);
        check("rst_pc8",   bus1.o_pc_8, 32'h8);
        check("rst_halt",  32'(bus1.o_halted), 32'h0);
        check("rst_mis",   32'(bus1.o_misaligned), 32'h0);
        check("rst_comm",  32'(bus1.o_committed), 32'h0);
        check("rst_pc_c4", bus4.o_pc, RV4);
        check("rst_ctx_c4", 32'(bus4.o_ctx), 32'h0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i > 0) drive(vecs[i].md, vecs[i].st, vecs[i].pw, vecs[i].np, vecs[i].hl, vecs[i].rs);
            else begin
                mode = vecs[i].md; step = vecs[i].st; pc_write = vecs[i].pw;
                npc = vecs[i].np; halt = vecs[i].hl; resume = vecs[i].rs;
            end
            @(posedge clk); #2;
            check($sformatf("v%0d_pc", i),   bus1.o_pc, vecs[i].pc);
            check($sformatf("v%0d_pc4", i),  bus1.o_pc_4, vecs[i].pc + 32'd4);
            check($sformatf("v%0d_pc8", i),  bus1.o_pc_8, vecs[i].pc + 32'd8);
            check($sformatf("v%0d_halt", i), 32'(bus1.o_halted), 32'(vecs[i].halted));
            check($sformatf("v%0d_mis", i),  32'(bus1.o_misaligned), 32'(vecs[i].mis));
            check($sformatf("v%0d_comm", i), 32'(bus1.o_committed), 32'(vecs[i].comm));
        end
        check("wrap_pc8", bus1.o_pc_8, 32'h0);

        // Four-context rotation
        @(negedge clk); rst_n = 1'b0; halt = 0; resume = 0; mode = 0; step = 0;
        @(negedge clk); rst_n = 1'b1; pc_write = 1; npc = 32'h100;
        @(posedge clk); #2; check("rot_ctx1", 32'(bus4.o_ctx), 32'd1);
        drive(0, 0, 1, 32'h200, 0, 0);
        @(posedge clk); #2; check("rot_ctx2", 32'(bus4.o_ctx), 32'd2);
        drive(0, 0, 1, 32'h300, 0, 0);
        @(posedge clk); #2; check("rot_ctx3", 32'(bus4.o_ctx), 32'd3);
        check("rot_pc3", bus4.o_pc, RV4);
        drive(0, 0, 1, 32'h400, 0, 0);
        @(posedge clk); #2; check("rot_ctx0", 32'(bus4.o_ctx), 32'd0);
        check("rot_pc0", bus4.o_pc, 32'h100);
        check("rot_c1pc", bus1.o_pc, 32'h400);

        // Halt at PC=0x8 then async reset while halted
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; pc_write = 1; npc = 32'h4;
        drive(0, 0, 1, 32'h8, 0, 0);
        drive(0, 0, 1, 32'hC, 1, 0);
        @(posedge clk); #2;
        check("hlt_pc", bus1.o_pc, 32'h8);
        check("hlt_flag", 32'(bus1.o_halted), 32'h1);
        #2; rst_n = 1'b0; #1;
        check("arst_pc", bus1.o_pc, RV1);
        check("arst_halt", 32'(bus1.o_halted), 32'h0);
        check("arst_pc_c4", bus4.o_pc, RV4);
        @(negedge clk); rst_n = 1'b1; halt = 0;

        // Randomised traffic against the reference model
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 2) == 0) step = ~step;
            pc_write = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 24) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            npc      = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
